fp32_to_bf16_conv: RTL and testbench

Streaming converter that narrows the fp32 accumulator results of the bfloat16 MAC datapath back to bfloat16 for write-out. It accepts one fp32 word per cycle over a valid/ready handshake and applies round-to-nearest-even, with denormal flush and NaN/Inf handling consistent with the fp32 adder's normalized-only arithmetic. Its two-stage registered pipeline, per-result status, and sticky status counters sit between the accumulator and the output buffer.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/bf16_round.sv | 52 +++++
 rtl/fp32_to_bf16_conv.sv | 96 +++++++++
 tb/tb_fp32_to_bf16_conv.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared bf16/fp32 field definitions, special-value constants and value classifier
// used by the fp32 adder and the fp32->bf16 narrowing path.
package fp_pkg;

  localparam int unsigned FP32_EXP_W = 8;
  localparam int unsigned FP32_MAN_W = 23;
  localparam int unsigned BF16_MAN_W = 7;

  localparam logic [FP32_EXP_W-1:0] EXP_MAX = 8'hFF;

  // Magnitude of canonical bf16 Inf, and the exponent+quiet-bit prefix of a bf16 qNaN
  localparam logic [FP32_EXP_W+BF16_MAN_W-1:0] BF16_INF_MAG  = {EXP_MAX, {BF16_MAN_W{1'b0}}};
  localparam logic [FP32_EXP_W:0]              BF16_QNAN_PFX = {EXP_MAX, 1'b1};

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_e;

  function automatic fp_class_e classify(input logic [31:0] x);
    logic [FP32_EXP_W-1:0] exp_f;
    logic [FP32_MAN_W-1:0] man_f;
    exp_f = x[30:23];
    man_f = x[FP32_MAN_W-1:0];
    if (exp_f == '0)          return ZERO;
    else if (exp_f != EXP_MAX) return NORM;
    else if (man_f == '0)     return INF;
    else                      return NAN;
  endfunction

endpackage

// File: rtl/bf16_round.sv
// Combinational fp32 -> bf16 narrowing: classify, round-to-nearest-even,
// denormal flush to signed zero, Inf/qNaN passthrough, inexact and overflow flags.
module bf16_round
  import fp_pkg::*;
(
  input  logic [31:0] in_data,
  output logic [15:0] res,
  output logic        inexact,
  output logic        ovf
);

  logic                  sgn;
  logic [FP32_MAN_W-1:0] man;
  logic                  lsb;
  logic                  guard;
  logic                  sticky;
  logic                  round_up;
  logic [15:0]           rounded;

  assign sgn      = in_data[31];
  assign man      = in_data[FP32_MAN_W-1:0];
  assign lsb      = in_data[16];
  assign guard    = in_data[15];
  assign sticky   = |in_data[14:0];
  assign round_up = guard & (sticky | lsb);
  // Mantissa carry ripples into the exponent; max finite exponent 254 lands on Inf, never the sign
  assign rounded  = in_data[31:16] + {15'b0, round_up};

  always_comb begin
    res     = '0;
    inexact = 1'b0;
    ovf     = 1'b0;
    unique case (classify(in_data))
      ZERO: begin
        res     = {sgn, 15'h0};
        inexact = |man;
      end
      INF: begin
        res = {sgn, BF16_INF_MAG};
      end
      NAN: begin
        res = {sgn, BF16_QNAN_PFX, man[21:16]};
      end
      NORM: begin
        res     = rounded;
        inexact = guard | sticky;
        ovf     = (rounded[14:7] == EXP_MAX);
      end
    endcase
  end

endmodule

// File: rtl/fp32_to_bf16_conv.sv
// Two-stage valid/ready fp32 -> bf16 converter with per-result flags,
// sticky status bits and a saturating delivered-result counter.
module fp32_to_bf16_conv
  import fp_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_inexact,
  output logic             out_ovf,
  input  logic             clr,
  output logic             sticky_inexact,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] conv_count
);

  logic        s1_valid;
  logic [15:0] s1_data;
  logic        s1_inexact;
  logic        s1_ovf;
  logic        s1_load;
  logic        s2_load;
  logic        out_hs;
  logic [15:0] rnd_data;
  logic        rnd_inexact;
  logic        rnd_ovf;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_hs   = out_valid && out_ready;

  bf16_round u_round (
    .in_data (in_data),
    .res     (rnd_data),
    .inexact (rnd_inexact),
    .ovf     (rnd_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_inexact <= 1'b0;
      s1_ovf     <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data    <= rnd_data;
        s1_inexact <= rnd_inexact;
        s1_ovf     <= rnd_ovf;
      end
    end
  end

  // Payload only moves with a valid word so an idle output keeps its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_inexact <= 1'b0;
      out_ovf     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= s1_data;
        out_inexact <= s1_inexact;
        out_ovf     <= s1_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_inexact <= 1'b0;
      sticky_ovf     <= 1'b0;
      conv_count     <= '0;
    end else if (clr) begin
      sticky_inexact <= 1'b0;
      sticky_ovf     <= 1'b0;
      conv_count     <= '0;
    end else if (out_hs) begin
      sticky_inexact <= sticky_inexact | out_inexact;
      sticky_ovf     <= sticky_ovf | out_ovf;
      if (conv_count != '1) conv_count <= conv_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp32_to_bf16_conv.sv
// Self-checking bench for fp32_to_bf16_conv: directed vectors, randomized
// backpressure streams, latency/throughput, status counters and mid-stream reset.
module tb_fp32_to_bf16_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_inexact;
  logic        out_ovf;
  logic        clr;
  logic        sticky_inexact;
  logic        sticky_ovf;
  logic [15:0] conv_count;

  logic        in_ready4;
  logic        out_valid4;
  logic [15:0] out_data4;
  logic        out_inexact4;
  logic        out_ovf4;
  logic        sticky_inexact4;
  logic        sticky_ovf4;
  logic [3:0]  conv_count4;

  always #5 clk = ~clk;

  fp32_to_bf16_conv dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inexact(out_inexact), .out_ovf(out_ovf), .clr(clr),
    .sticky_inexact(sticky_inexact), .sticky_ovf(sticky_ovf), .conv_count(conv_count)
  );

  fp32_to_bf16_conv #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_inexact(out_inexact4), .out_ovf(out_ovf4), .clr(clr),
    .sticky_inexact(sticky_inexact4), .sticky_ovf(sticky_ovf4), .conv_count(conv_count4)
  );

  int          checks = 0;
  int          errors = 0;
  logic [17:0] q[$];
  logic [17:0] cur_exp;
  int unsigned m_cnt;
  logic        m_sinx, m_sovf;
  logic        held;
  logic [15:0] held_data;
  logic        last_acc;
  int          tick_n = 0;
  logic        arm = 1'b0;
  int          first_acc, first_ov, last_ov, ov_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {inexact, ovf, bf16} from integer arithmetic on the fp32 word
  function automatic logic [17:0] ref_conv(input logic [31:0] x);
    int unsigned e, m, hi, lo;
    logic inx, ov;
    logic [15:0] d;
    e = (x >> 23) & 32'd255;
    m = x & 32'h7FFFFF;
    hi = x >> 16;
    lo = x & 32'hFFFF;
    inx = 1'b0;
    ov = 1'b0;
    if (e == 0) begin
      d = 16'(hi & 32'h8000);
      inx = (m != 0);
    end else if (e == 255) begin
      d = (m == 0) ? 16'(hi & 32'hFF80) : 16'(hi | 32'h0040);
    end else begin
      if (lo > 32'h8000 || (lo == 32'h8000 && (hi % 2) == 1)) hi = hi + 1;
      d = 16'(hi);
      ov = (((hi >> 7) & 32'd255) == 255);
      inx = (lo != 0);
    end
    return {inx, ov, d};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int unsigned sel;
    w = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0: w[30:23] = 8'h00;
      1: w[30:23] = 8'hFF;
      2: begin w[30:23] = 8'hFE; w[22:16] = 7'h7F; end
      3: w[15:0] = 16'h8000;
      default: ;
    endcase
    return w;
  endfunction

  task automatic tick();
    logic acc, hs;
    logic [17:0] e;
    int unsigned exp_cnt4;
    #1;
    exp_cnt4 = (m_cnt > 15) ? 15 : m_cnt;
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2 || out_ready));
    chk("in_ready4", 32'(in_ready4), 32'(q.size() < 2 || out_ready));
    chk("conv_count", 32'(conv_count), m_cnt);
    chk("conv_count4", 32'(conv_count4), exp_cnt4);
    chk("sticky_inexact", 32'(sticky_inexact), 32'(m_sinx));
    chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sovf));
    chk("sticky_inexact4", 32'(sticky_inexact4), 32'(m_sinx));
    chk("sticky_ovf4", 32'(sticky_ovf4), 32'(m_sovf));
    if (held) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(held_data));
    end
    if (q.size() == 0) begin
      chk("empty_valid", 32'(out_valid), 32'd0);
      chk("empty_valid4", 32'(out_valid4), 32'd0);
    end
    hs = out_valid && out_ready;
    if (hs && q.size() > 0) begin
      e = q.pop_front();
      chk("out_data", 32'(out_data), 32'(e[15:0]));
      chk("out_ovf", 32'(out_ovf), 32'(e[16]));
      chk("out_inexact", 32'(out_inexact), 32'(e[17]));
      chk("out_data4", 32'(out_data4), 32'(e[15:0]));
      chk("out_flags4", 32'({out_inexact4, out_ovf4}), 32'(e[17:16]));
    end
    acc = in_valid && in_ready;
    last_acc = acc;
    held = out_valid && !out_ready;
    held_data = out_data;
    if (arm) begin
      if (acc && first_acc < 0) first_acc = tick_n;
      if (out_valid) begin
        if (first_ov < 0) first_ov = tick_n;
        last_ov = tick_n;
        ov_cnt++;
      end
    end
    @(posedge clk);
    if (acc) q.push_back(cur_exp);
    if (clr) begin
      m_cnt = 0; m_sinx = 1'b0; m_sovf = 1'b0;
    end else if (hs && q.size() >= 0) begin
      if (m_cnt < 65535) m_cnt++;
      m_sinx = m_sinx | out_inexact;
      m_sovf = m_sovf | out_ovf;
    end
    tick_n++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_flags", 32'({out_inexact, out_ovf}), 32'd0);
    chk("rst_sticky", 32'({sticky_inexact, sticky_ovf}), 32'd0);
    chk("rst_count", 32'(conv_count), 32'd0);
    chk("rst_count4", 32'(conv_count4), 32'd0);
    q.delete();
    m_cnt = 0; m_sinx = 1'b0; m_sovf = 1'b0;
    held = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && q.size() > 0; i++) tick();
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic send(input logic [31:0] w, input logic [17:0] e);
    in_data = w;
    cur_exp = e;
    in_valid = 1'b1;
    out_ready = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 10 && !last_acc; i++) tick();
    chk("send_accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    in_data = rand_word();
    cur_exp = ref_conv(in_data);
  endtask

  logic [31:0] dir_in  [10];
  logic [17:0] dir_exp [10];
  int          n;

  initial begin
    dir_in  = '{32'h3F800000, 32'h3F808000, 32'h3F818000, 32'h3F80C000, 32'h7F7FFFFF,
                32'hFF800000, 32'h7FA10000, 32'h80000001, 32'h00000000, 32'h7F800000};
    dir_exp = '{{2'b00, 16'h3F80}, {2'b10, 16'h3F80}, {2'b10, 16'h3F82}, {2'b10, 16'h3F81},
                {2'b11, 16'h7F80}, {2'b00, 16'hFF80}, {2'b00, 16'h7FE1}, {2'b10, 16'h8000},
                {2'b00, 16'h0000}, {2'b00, 16'h7F80}};
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr = 1'b0; cur_exp = '0;
    held = 1'b0; last_acc = 1'b0;
    do_reset();

    // Directed exact, tie and special-value vectors
    for (int i = 0; i < 10; i++) begin
      send(dir_in[i], dir_exp[i]);
      drain();
    end

    // Latency and throughput with continuous input and no backpressure
    arm = 1'b1; first_acc = -1; first_ov = -1; last_ov = -1; ov_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      send_rand();
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    arm = 1'b0;
    chk("latency", 32'(first_ov - first_acc), 32'd2);
    chk("throughput_span", 32'(last_ov - first_ov), 32'd9);
    chk("throughput_count", 32'(ov_cnt), 32'd10);

    // Eight words under pseudo-random backpressure
    n = 0;
    for (int g = 0; g < 200 && n < 8; g++) begin
      if (!in_valid || last_acc) send_rand();
      in_valid = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (last_acc) n++;
    end
    chk("bp_accepted", 32'(n), 32'd8);
    in_valid = 1'b0;
    for (int g = 0; g < 10; g++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // Status: three inexact then one exact
    clr = 1'b1; tick(); clr = 1'b0;
    send(32'h3F808000, {2'b10, 16'h3F80});
    send(32'h3F818000, {2'b10, 16'h3F82});
    send(32'h3F80C000, {2'b10, 16'h3F81});
    send(32'h3F800000, {2'b00, 16'h3F80});
    drain();
    chk("status_count", 32'(conv_count), 32'd4);
    chk("status_sticky_inexact", 32'(sticky_inexact), 32'd1);
    chk("status_sticky_ovf", 32'(sticky_ovf), 32'd0);

    // Clear coincident with an output handshake
    in_data = 32'h7F7FFFFF; cur_exp = {2'b11, 16'h7F80};
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_pre_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_count", 32'(conv_count), 32'd0);
    chk("clr_sticky", 32'({sticky_inexact, sticky_ovf}), 32'd0);
    chk("clr_count4", 32'(conv_count4), 32'd0);

    // Counter saturation on the narrow instance
    n = 0;
    for (int g = 0; g < 100 && n < 20; g++) begin
      send_rand();
      in_valid = 1'b1;
      out_ready = 1'b1;
      tick();
      if (last_acc) n++;
    end
    drain();
    chk("sat_count16", 32'(conv_count), 32'd20);
    chk("sat_count4", 32'(conv_count4), 32'd15);

    // Reset with both stages full and stalled
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_rand();
      tick();
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    do_reset();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Longer random stream with random backpressure
    for (int g = 0; g < 120; g++) begin
      if (!in_valid || last_acc) send_rand();
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
